// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle datapath (master) and its control FSM (slave).
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic       illegal;
  logic       bus_err;
  logic       instr_done;

  modport master (
    output op, zero, mem_ready,
    input  pc_write, ir_write, mem_write, reg_write, adr_src,
    input  alu_src_a, alu_src_b, alu_op, result_src, imm_src,
    input  illegal, bus_err, instr_done
  );

  modport slave (
    input  op, zero, mem_ready,
    output pc_write, ir_write, mem_write, reg_write, adr_src,
    output alu_src_a, alu_src_b, alu_op, result_src, imm_src,
    output illegal, bus_err, instr_done
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V style control FSM with memory-stall timeout and trap handling.
// Strobes are decoded from state/op; fault flags and instr_done are registered.
module multicycle_control_fsm #(
  parameter int EN_JAL    = 1,
  parameter int TRAP_HALT = 1,
  parameter int MAX_WAIT  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_control_fsm_if.slave bus
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       done_q, done_d;

  logic       pc_write_s, ir_write_s, mem_write_s, reg_write_s, adr_src_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, alu_op_s, result_src_s;
  logic [2:0] imm_src_s;
  logic       mem_wait_s;

  // State, wait counter, sticky fault flags and the instr_done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      done_q    <= done_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d      = state_q;
    wait_d       = 8'd0;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    done_d       = 1'b0;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    result_src_s = 2'b00;
    mem_wait_s   = 1'b0;

    case (bus.op)
      OP_SW:   imm_src_s = 3'b001;
      OP_BEQ:  imm_src_s = 3'b010;
      OP_JAL:  imm_src_s = 3'b011;
      default: imm_src_s = 3'b000;
    endcase

    case (state_q)
      S_FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = bus.mem_ready;
        pc_write_s   = bus.mem_ready;
        mem_wait_s   = 1'b1;
        if (bus.mem_ready) state_d = S_DECODE;
        else               state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL: begin
            if (EN_JAL != 0) begin
              state_d = S_JAL;
            end else begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        if (bus.op == OP_SW) state_d = S_MEMWRITE;
        else                 state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_s  = 1'b1;
        mem_wait_s = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
        else               state_d = S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        mem_wait_s  = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
        else               state_d = S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        pc_write_s  = bus.zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_TRAP: begin
        if (TRAP_HALT != 0) state_d = S_TRAP;
        else                state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A stall on the last allowed cycle traps; a ready in that same cycle completes instead
    if (mem_wait_s && !bus.mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        state_d   = S_TRAP;
        bus_err_d = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end else begin
      wait_d = 8'd0;
    end

    case (state_q)
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: done_d = (state_d == S_FETCH);
      default:                             done_d = 1'b0;
    endcase
  end

  // Strobes are forced low for the whole time reset is asserted
  assign bus.pc_write   = pc_write_s  & rst_n;
  assign bus.ir_write   = ir_write_s  & rst_n;
  assign bus.mem_write  = mem_write_s & rst_n;
  assign bus.reg_write  = reg_write_s & rst_n;
  assign bus.adr_src    = adr_src_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.result_src = result_src_s;
  assign bus.imm_src    = imm_src_s;
  assign bus.illegal    = illegal_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.instr_done = done_q;

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter EN_JAL, default 1, meaning jal (7'b1101111) is decoded when 1 and trapped when 0.
REQ-002 SHALL have parameter TRAP_HALT, default 1, meaning 1 = TRAP is terminal and 0 = TRAP returns to FETCH after one cycle.
REQ-003 SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of stalled cycles per memory access (range 1..255).
REQ-004 SHALL have ports: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: op input 7, IR opcode; zero input 1, ALU zero flag; mem_ready input 1, memory access complete.
REQ-006 SHALL have ports: pc_write, ir_write, mem_write, reg_write, adr_src, each output 1 (write strobes and address select, 0=PC 1=Result).
REQ-007 SHALL have ports: alu_src_a output 2 (00 PC, 01 OldPC, 10 RegA); alu_src_b output 2 (00 RegB, 01 Imm, 10 const 4); alu_op output 2; result_src output 2 (00 ALUOut, 01 Data, 10 ALUResult).
REQ-008 SHALL have ports: imm_src output 3 (I 000, S 001, B 010, J 011); illegal output 1; bus_err output 1; instr_done output 1.

Function
REQ-009 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP, registered on rising clk.
REQ-010 SHALL drive unlisted outputs to 0 in every state; all outputs are decoded from state and op, except where gated by mem_ready or zero as stated below.
REQ-011 FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready; advance to DECODE on mem_ready, else hold.
REQ-012 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00 and route on op: lw/sw to MEMADR, 0110011 to EXECR, 0010011 to EXECI, beq to BEQ, jal to JAL (EN_JAL=1 only), any other opcode to TRAP.
REQ-013 imm_src SHALL decode from op in every state: sw 001, beq 010, jal 011, else 000.
REQ-014 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00; route lw to MEMREAD, sw to MEMWRITE.
REQ-015 MEMREAD SHALL drive adr_src=1, result_src=00; on mem_ready go to MEMWB.
REQ-016 MEMWB SHALL drive result_src=01, reg_write=1; go to FETCH.
REQ-017 MEMWRITE SHALL drive adr_src=1, result_src=00, and hold mem_write=1 through all stall cycles; on mem_ready go to FETCH.
REQ-018 EXECR SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10 and go to ALUWB; EXECI is identical with alu_src_b=01.
REQ-019 ALUWB SHALL drive result_src=00, reg_write=1; go to FETCH.
REQ-020 BEQ SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; go to FETCH.
REQ-021 JAL SHALL drive alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; go to ALUWB.
REQ-022 A wait counter SHALL clear on entry to FETCH/MEMREAD/MEMWRITE and increment per stalled cycle; if it reaches MAX_WAIT without mem_ready, the FSM SHALL go to TRAP and assert bus_err with all strobes 0.
REQ-023 If mem_ready arrives in the same cycle the counter reaches MAX_WAIT, completion SHALL win; no trap occurs.
REQ-024 TRAP SHALL assert illegal (opcode cause) or bus_err (timeout cause) with all strobes 0; if TRAP_HALT=1, hold until reset; if TRAP_HALT=0, flags are sticky until reset and the next state is FETCH.
REQ-025 instr_done SHALL pulse for one cycle on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, or BEQ.

Reset
REQ-026 rst_n low SHALL asynchronously set state=FETCH, clear the wait counter, illegal, and bus_err, and force pc_write, ir_write, mem_write, reg_write, and instr_done to 0 while asserted.
REQ-027 The first fetch strobe SHALL occur no earlier than the first rising clk after rst_n deasserts; a reset mid-access SHALL abandon the access with no write strobe.

Verification
REQ-028 add (0110011), mem_ready=1 always -> states FETCH, DECODE, EXECR, ALUWB; reg_write=1 in cycle 4; instr_done=1 in cycle 5.
REQ-029 lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with result_src=01, reg_write=1.
REQ-030 beq with zero=0, then beq with zero=1 -> pc_write=0 in the first BEQ cycle and pc_write=1 in the second.
REQ-031 op=1101111 with EN_JAL=0 -> TRAP and illegal=1; with TRAP_HALT=1, the FSM stays in TRAP for 20 cycles.
REQ-032 MAX_WAIT=3 with sw and mem_ready never asserted -> mem_write=1 for 3 cycles, then TRAP with bus_err=1 and mem_write=0.
REQ-033 rst_n pulsed low during a stalled MEMWRITE -> mem_write=0 immediately; FETCH resumes after release with illegal=bus_err=0.
